// File: rtl/recip_nr.sv
// Newton-Raphson reciprocal of a normalized 8-bit mantissa, Q2.14 result, one shared multiplier.
// Optional macro RECIP_NR_ROUND_EN adds half-LSB rounding in the MULP/MULY steps.
module recip_nr #(
    parameter int ITERS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] d_in,
    input  logic [4:0]  sh_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] recip,
    output logic [4:0]  exp_out,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, SEED, MULP, MULY, DONE} state_t;

    localparam logic [1:0] ITERS_W = ITERS[1:0];

`ifdef RECIP_NR_ROUND_EN
    localparam logic [32:0] RND_P = 33'h0_0000_8000;
    localparam logic [32:0] RND_Y = 33'h0_0000_2000;
`else
    localparam logic [32:0] RND_P = 33'h0;
    localparam logic [32:0] RND_Y = 33'h0;
`endif

    state_t      state_q, state_d;
    logic [15:0] m_q, y_q;
    logic [16:0] e_q;
    logic [1:0]  iter_q;
    logic [4:0]  exp_q;
    logic        err_q;

    logic        accept, bad;
    logic [15:0] mul_a;
    logic [16:0] mul_b;
    logic [32:0] prod, p_full, y_full;
    logic [15:0] y_seed, y_new;
    logic [16:0] e_new;

    assign accept = in_valid && in_ready;
    assign bad    = (d_in[15:8] != 8'h00) || (d_in < 16'h0080);

    // The single multiplier; operand selection follows the FSM step.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            SEED: begin mul_a = m_q; mul_b = 17'd30840;      end
            MULP: begin mul_a = m_q; mul_b = {1'b0, y_q};    end
            MULY: begin mul_a = y_q; mul_b = e_q;            end
            default: ;
        endcase
    end

    assign prod   = {17'b0, mul_a} * {16'b0, mul_b};
    assign y_seed = 16'(33'h0_0000_B4B5 - (prod >> 16));
    assign p_full = (prod + RND_P) >> 16;
    assign e_new  = (p_full >= 33'h0_0000_8000) ? 17'h0 : 17'(33'h0_0000_8000 - p_full);
    assign y_full = (prod + RND_Y) >> 14;
    assign y_new  = (y_full > 33'h0_0000_FFFF) ? 16'hFFFF : y_full[15:0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = bad ? DONE : SEED;
            SEED:    state_d = MULP;
            MULP:    state_d = MULY;
            MULY:    state_d = (iter_q + 2'd1 == ITERS_W) ? DONE : MULP;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q    <= '0;
            y_q    <= '0;
            e_q    <= '0;
            iter_q <= '0;
            exp_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    m_q    <= {d_in[7:0], 8'h00};
                    exp_q  <= sh_in;
                    iter_q <= '0;
                    err_q  <= bad;
                    if (bad) y_q <= 16'hFFFF;
                end
                SEED: y_q <= y_seed;
                MULP: e_q <= e_new;
                MULY: begin
                    y_q    <= y_new;
                    iter_q <= iter_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign recip   = y_q;
    assign exp_out = exp_q;
    assign err     = err_q;

endmodule

// File: tb/tb_recip_nr.sv
// Directed bench for recip_nr: reset, range corners, error path, backpressure, mid-op reset.
module tb_recip_nr;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [15:0] d_in;
    logic [4:0]  sh_in;
    logic        in_ready, out_valid, err;
    logic [15:0] recip;
    logic [4:0]  exp_out;

    int nvec = 0;
    int nmis = 0;

    recip_nr #(.ITERS(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .d_in(d_in), .sh_in(sh_in), .out_valid(out_valid), .out_ready(out_ready),
        .recip(recip), .exp_out(exp_out), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        nvec++;
        assert (obs === expv) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Result must land within +-3 LSB of floor(2^22/d).
    task automatic chk_tol(input string tag, input int obs, input int target);
        nvec++;
        assert (((obs >= target - 3) && (obs <= target + 3)) === 1'b1) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h+-3", tag, obs, target);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic accept_op(input logic [15:0] d, input logic [4:0] sh, input string tag);
        in_valid = 1'b1;
        d_in     = d;
        sh_in    = sh;
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drained_ov"}, int'(out_valid), 0);
        chk({tag, "_drained_ir"}, int'(in_ready), 1);
    endtask

    task automatic run_good(input logic [15:0] d, input logic [4:0] sh, input int target, input string tag);
        int lat;
        accept_op(d, sh, tag);
        wait_valid(lat);
        chk({tag, "_latency"}, lat, 5);
        chk_tol({tag, "_recip"}, int'(recip), target);
        chk({tag, "_exp"}, int'(exp_out), int'(sh));
        chk({tag, "_err"}, int'(err), 0);
        drain(tag);
    endtask

    task automatic run_bad(input logic [15:0] d, input logic [4:0] sh, input string tag);
        int lat;
        accept_op(d, sh, tag);
        wait_valid(lat);
        chk({tag, "_latency"}, lat, 0);
        chk({tag, "_recip"}, int'(recip), 'hFFFF);
        chk({tag, "_exp"}, int'(exp_out), int'(sh));
        chk({tag, "_err"}, int'(err), 1);
        drain(tag);
    endtask

    initial begin
        int lat;
        logic seen_ov;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d_in = '0; sh_in = '0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready), 1);
        chk("rst_recip",     int'(recip), 0);
        chk("rst_exp",       int'(exp_out), 0);
        chk("rst_err",       int'(err), 0);

        run_good(16'h0080, 5'd3,  'h8000, "low");
        run_good(16'h00C0, 5'd7,  'h5555, "mid");
        run_good(16'h00FF, 5'd31, 'h4040, "top");
        run_bad (16'h0000, 5'd5,  "err_zero");
        run_bad (16'h0100, 5'd1,  "err_big");
        run_good(16'h0080, 5'd0,  'h8000, "after_err");

        // Backpressure with a second operand already waiting upstream.
        accept_op(16'h00C0, 5'd9, "bp");
        wait_valid(lat);
        chk("bp_latency", lat, 5);
        in_valid = 1'b1; d_in = 16'h00A0; sh_in = 5'd2; out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_tol("bp_hold_recip", int'(recip), 'h5555);
            chk("bp_hold_exp", int'(exp_out), 9);
            chk("bp_hold_err", int'(err), 0);
            chk("bp_hold_ov",  int'(out_valid), 1);
            chk("bp_hold_ir",  int'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_ov", int'(out_valid), 0);
        chk("bp_release_ir", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("bp_second_taken", int'(in_ready), 0);
        wait_valid(lat);
        chk("bp2_latency", lat, 5);
        chk_tol("bp2_recip", int'(recip), 'h6666);
        chk("bp2_exp", int'(exp_out), 2);
        drain("bp2");

        // Reset while the FSM sits in MULP.
        accept_op(16'h0080, 5'd4, "abort");
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ov",    int'(out_valid), 0);
        chk("abort_ir",    int'(in_ready), 1);
        chk("abort_recip", int'(recip), 0);
        chk("abort_exp",   int'(exp_out), 0);
        chk("abort_err",   int'(err), 0);
        seen_ov = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen_ov = 1'b1;
        end
        chk("abort_no_ov", int'(seen_ov), 0);
        chk("abort_idle",  int'(in_ready), 1);
        run_good(16'h00A0, 5'd6, 'h6666, "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
